bp_resolver: RTL and testbench

- Resolution side of the IF/ID branch-prediction interface in the RV32 pipeline.
- Records each prediction issued at IF into an in-flight queue.
- Retires the oldest record when ID resolves the branch, and flags a mispredict with the redirect PC.
- Trains a 2-bit saturating-counter branch history table (BHT) that the IF-stage predictor reads, and keeps branch/mispredict statistics.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_inflight_fifo.sv | 79 +++++++
 rtl/bp_resolver.sv | 145 ++++++++++++++
 tb/tb_bp_resolver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bp_pkg : shared record type, counter encodings and training helper
// Rev 1.0
// ------------------------------------------------------------------
package bp_pkg;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   localparam logic [1:0] CTR_WNT = 2'b01;

   typedef struct packed {
      logic        taken;
      logic [31:0] pc;
      logic [31:0] target;
      logic [31:0] fallthru;
   } pred_rec_t;

   localparam int REC_W = $bits(pred_rec_t);

   function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == ST) ? ST : ctr + 2'd1;
      end
      return (ctr == SNT) ? SNT : ctr - 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// bp_inflight_fifo : queue of outstanding predictions, with flush
// Rev 1.0
// ------------------------------------------------------------------
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [REC_W-1:0] wr_data,
   output logic [REC_W-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [REC_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] count_q, count_d;

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (count_q == DEPTH_OCC);
   assign empty   = (count_q == '0);

   // The caller guarantees push/pop legality; clear overrides both.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: rtl/bp_resolver.sv
`default_nettype none
// ------------------------------------------------------------------
// bp_resolver : retires IF predictions at ID, trains the BHT, counts
// Rev 1.0
// ------------------------------------------------------------------
module bp_resolver
   import bp_pkg::*;
#(
   parameter int IDX_W      = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             pred_valid,
   input  logic             pred_taken,
   input  logic [31:0]      pred_pc,
   input  logic [31:0]      pred_target,
   input  logic [31:0]      pred_fallthru,
   input  logic             res_valid,
   input  logic             res_taken,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_ctr,
   output logic             upd_valid,
   output logic [IDX_W-1:0] upd_idx,
   output logic [1:0]       upd_ctr,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             err_overflow,
   output logic             err_underflow,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mispred_count
);

   localparam int ENTRIES = 1 << IDX_W;

   pred_rec_t        head;
   logic [REC_W-1:0] head_bits;
   logic [REC_W-1:0] push_bits;
   logic             push_req, res_req, do_push, do_pop;
   logic [IDX_W-1:0] trn_idx;
   logic [1:0]       trn_ctr;
   logic             unused_pc_bits;

   logic [1:0]       bht_q [ENTRIES];
   logic [1:0]       bht_d [ENTRIES];
   logic             upd_valid_q, upd_valid_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic [1:0]       upd_ctr_q, upd_ctr_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_und_q, err_und_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

   assign push_bits = {pred_taken, pred_pc, pred_target, pred_fallthru};
   assign head      = pred_rec_t'(head_bits);

   assign push_req   = pred_valid && !stall;
   assign res_req    = res_valid && !stall;
   assign do_pop     = res_req && !fifo_empty;
   assign mispredict = do_pop && (head.taken != res_taken);
   // A mispredict flushes wrong-path records, including any arriving now.
   assign do_push    = push_req && !mispredict && (!fifo_full || do_pop);

   assign redirect_pc = mispredict ? (head.taken ? head.fallthru : head.target) : 32'd0;

   assign trn_idx = head.pc[IDX_W+1:2];
   assign trn_ctr = ctr_train(bht_q[trn_idx], res_taken);
   assign rd_ctr  = (do_pop && (rd_idx == trn_idx)) ? trn_ctr : bht_q[rd_idx];

   assign unused_pc_bits = ^{head.pc[31:IDX_W+2], head.pc[1:0]};

   bp_inflight_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (mispredict),
      .push    (do_push),
      .pop     (do_pop),
      .wr_data (push_bits),
      .rd_data (head_bits),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      bht_d       = bht_q;
      upd_valid_d = do_pop;
      upd_idx_d   = upd_idx_q;
      upd_ctr_d   = upd_ctr_q;
      err_ovf_d   = err_ovf_q | (push_req && fifo_full && !do_pop);
      err_und_d   = err_und_q | (res_req && fifo_empty);
      br_cnt_d    = br_cnt_q;
      mis_cnt_d   = mis_cnt_q;
      if (do_pop) begin
         bht_d[trn_idx] = trn_ctr;
         upd_idx_d      = trn_idx;
         upd_ctr_d      = trn_ctr;
         if (br_cnt_q != {CNT_W{1'b1}}) begin
            br_cnt_d = br_cnt_q + 1'b1;
         end
         if (mispredict && (mis_cnt_q != {CNT_W{1'b1}})) begin
            mis_cnt_d = mis_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht_q[i] <= CTR_WNT;
         end
         upd_valid_q <= 1'b0;
         upd_idx_q   <= '0;
         upd_ctr_q   <= 2'b00;
         err_ovf_q   <= 1'b0;
         err_und_q   <= 1'b0;
         br_cnt_q    <= '0;
         mis_cnt_q   <= '0;
      end else begin
         bht_q       <= bht_d;
         upd_valid_q <= upd_valid_d;
         upd_idx_q   <= upd_idx_d;
         upd_ctr_q   <= upd_ctr_d;
         err_ovf_q   <= err_ovf_d;
         err_und_q   <= err_und_d;
         br_cnt_q    <= br_cnt_d;
         mis_cnt_q   <= mis_cnt_d;
      end
   end

   assign upd_valid     = upd_valid_q;
   assign upd_idx       = upd_idx_q;
   assign upd_ctr       = upd_ctr_q;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_und_q;
   assign br_count      = br_cnt_q;
   assign mispred_count = mis_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_resolver.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_bp_resolver : directed vector table plus reset sequences
// Rev 1.0
// ------------------------------------------------------------------
module tb_bp_resolver;

   localparam logic [96:0] REC_N = 97'd0;
   localparam logic [96:0] REC_A = {1'b1, 32'h100, 32'h0F0, 32'h104};
   localparam logic [96:0] REC_B = {1'b0, 32'h200, 32'h240, 32'h204};
   localparam logic [96:0] REC_C = {1'b1, 32'h108, 32'h300, 32'h10C};
   localparam logic [96:0] REC_D = {1'b0, 32'h11C, 32'h400, 32'h120};
   localparam logic [96:0] REC_E = {1'b0, 32'h130, 32'h500, 32'h134};
   localparam int NVEC = 22;

   logic        clk = 1'b0;
   logic        rst_n, stall, pred_valid, pred_taken, res_valid, res_taken;
   logic [31:0] pred_pc, pred_target, pred_fallthru;
   logic [3:0]  rd_idx;
   logic        mispredict, upd_valid, fifo_full, fifo_empty, err_overflow, err_underflow;
   logic [31:0] redirect_pc, br_count, mispred_count;
   logic [1:0]  rd_ctr, upd_ctr;
   logic [3:0]  upd_idx;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int stall, pv; logic [96:0] rec; int rv, rt, rdi;
      int mis, rpc, rdc, uv, ui, uc, full, empty, eo, eu, br, mc;
   } vec_t;

   vec_t vecs [NVEC];

   bp_resolver #(.IDX_W(4), .FIFO_DEPTH(2), .CNT_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .pred_valid    (pred_valid),
      .pred_taken    (pred_taken),
      .pred_pc       (pred_pc),
      .pred_target   (pred_target),
      .pred_fallthru (pred_fallthru),
      .res_valid     (res_valid),
      .res_taken     (res_taken),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc),
      .rd_idx        (rd_idx),
      .rd_ctr        (rd_ctr),
      .upd_valid     (upd_valid),
      .upd_idx       (upd_idx),
      .upd_ctr       (upd_ctr),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .br_count      (br_count),
      .mispred_count (mispred_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int stall_i, input int pv, input logic [96:0] rec,
                               input int rv, input int rt, input int rdi,
                               input int mis, input int rpc, input int rdc, input int uv,
                               input int ui, input int uc, input int full, input int empty,
                               input int eo, input int eu, input int br, input int mc);
      vec_t v;
      v.stall = stall_i; v.pv = pv; v.rec = rec; v.rv = rv; v.rt = rt; v.rdi = rdi;
      v.mis = mis; v.rpc = rpc; v.rdc = rdc; v.uv = uv; v.ui = ui; v.uc = uc;
      v.full = full; v.empty = empty; v.eo = eo; v.eu = eu; v.br = br; v.mc = mc;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== 32'(exp)) begin
         n_errors++;
         $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
      end
   endtask

   // Drive a vector, check at the falling edge, then let the rising edge act on it.
   task automatic apply(input vec_t v, input int row);
      stall      = v.stall[0];
      pred_valid = v.pv[0];
      {pred_taken, pred_pc, pred_target, pred_fallthru} = v.rec;
      res_valid  = v.rv[0];
      res_taken  = v.rt[0];
      rd_idx     = v.rdi[3:0];
      @(negedge clk);
      chk("mispredict",    row, 32'(mispredict),    v.mis);
      chk("redirect_pc",   row, redirect_pc,        v.rpc);
      chk("rd_ctr",        row, 32'(rd_ctr),        v.rdc);
      chk("upd_valid",     row, 32'(upd_valid),     v.uv);
      chk("upd_idx",       row, 32'(upd_idx),       v.ui);
      chk("upd_ctr",       row, 32'(upd_ctr),       v.uc);
      chk("fifo_full",     row, 32'(fifo_full),     v.full);
      chk("fifo_empty",    row, 32'(fifo_empty),    v.empty);
      chk("err_overflow",  row, 32'(err_overflow),  v.eo);
      chk("err_underflow", row, 32'(err_underflow), v.eu);
      chk("br_count",      row, br_count,           v.br);
      chk("mispred_count", row, mispred_count,      v.mc);
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                stall pv rec   rv rt rdi  mis rpc    rdc uv ui uc full empty eo eu br mc
      vecs[0]  = mk(0, 0, REC_N, 0, 0, 0,  0, 0,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      vecs[1]  = mk(0, 1, REC_A, 0, 0, 0,  0, 0,     1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      vecs[2]  = mk(0, 0, REC_N, 1, 1, 0,  0, 0,     2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 1, REC_B, 0, 0, 0,  0, 0,     2, 1, 0, 2, 0, 1, 0, 0, 1, 0);
      vecs[4]  = mk(0, 0, REC_N, 1, 1, 0,  1, 'h240, 3, 0, 0, 2, 0, 0, 0, 0, 1, 0);
      vecs[5]  = mk(0, 0, REC_N, 0, 0, 0,  0, 0,     3, 1, 0, 3, 0, 1, 0, 0, 2, 1);
      vecs[6]  = mk(0, 1, REC_C, 0, 0, 2,  0, 0,     1, 0, 0, 3, 0, 1, 0, 0, 2, 1);
      vecs[7]  = mk(0, 1, REC_D, 0, 0, 7,  0, 0,     1, 0, 0, 3, 0, 0, 0, 0, 2, 1);
      vecs[8]  = mk(0, 1, REC_E, 0, 0, 0,  0, 0,     3, 0, 0, 3, 1, 0, 0, 0, 2, 1);
      vecs[9]  = mk(0, 1, REC_A, 1, 1, 2,  0, 0,     2, 0, 0, 3, 1, 0, 1, 0, 2, 1);
      vecs[10] = mk(0, 0, REC_N, 0, 0, 2,  0, 0,     2, 1, 2, 2, 1, 0, 1, 0, 3, 1);
      vecs[11] = mk(0, 0, REC_N, 1, 0, 7,  0, 0,     0, 0, 2, 2, 1, 0, 1, 0, 3, 1);
      vecs[12] = mk(0, 1, REC_C, 1, 0, 0,  1, 'h104, 2, 1, 7, 0, 0, 0, 1, 0, 4, 1);
      vecs[13] = mk(0, 0, REC_N, 1, 1, 0,  0, 0,     2, 1, 0, 2, 0, 1, 1, 0, 5, 2);
      vecs[14] = mk(1, 1, REC_C, 0, 0, 0,  0, 0,     2, 0, 0, 2, 0, 1, 1, 1, 5, 2);
      vecs[15] = mk(0, 1, REC_A, 0, 0, 0,  0, 0,     2, 0, 0, 2, 0, 1, 1, 1, 5, 2);
      vecs[16] = mk(1, 0, REC_N, 1, 1, 0,  0, 0,     2, 0, 0, 2, 0, 0, 1, 1, 5, 2);
      vecs[17] = mk(0, 0, REC_N, 1, 1, 0,  0, 0,     3, 0, 0, 2, 0, 0, 1, 1, 5, 2);
      vecs[18] = mk(0, 1, REC_A, 0, 0, 0,  0, 0,     3, 1, 0, 3, 0, 1, 1, 1, 6, 2);
      vecs[19] = mk(0, 0, REC_N, 1, 1, 0,  0, 0,     3, 0, 0, 3, 0, 0, 1, 1, 6, 2);
      vecs[20] = mk(1, 1, REC_C, 1, 1, 0,  0, 0,     3, 1, 0, 3, 0, 1, 1, 1, 7, 2);
      vecs[21] = mk(0, 0, REC_N, 0, 0, 0,  0, 0,     3, 0, 0, 3, 0, 1, 1, 1, 7, 2);

      rst_n = 1'b0; stall = 1'b0; pred_valid = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
      {pred_taken, pred_pc, pred_target, pred_fallthru} = REC_N;
      rd_idx = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Every table entry starts weakly not-taken.
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         @(negedge clk);
         chk("reset_rd_ctr", i, 32'(rd_ctr), 1);
         @(posedge clk);
         #1;
      end

      for (int r = 0; r < NVEC; r++) begin
         apply(vecs[r], r);
      end

      // Reset with two records in flight: everything returns to reset state.
      apply(mk(0, 1, REC_C, 0, 0, 2, 0, 0, 2, 0, 0, 3, 0, 1, 1, 1, 7, 2), 100);
      apply(mk(0, 1, REC_D, 0, 0, 7, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1, 7, 2), 101);
      chk("pre_reset_full", 102, 32'(fifo_full), 1);
      rst_n = 1'b0;
      stall = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(mk(0, 0, REC_N, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0), 103);
      apply(mk(0, 0, REC_N, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0), 104);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
